// File: rtl/stream_to_axi_r_pkg.sv
// Shared definitions for the receive-side AXI R stream block: FSM states,
// stream type codes common with the transmit taps, and metadata field offsets.
package stream_to_axi_r_pkg;

  typedef enum logic [1:0] {
    WAIT_DATA = 2'd0,
    WAIT_META = 2'd1,
    DRIVE     = 2'd2
  } r_state_e;

  // Type codes carried in the top bits of every metadata word.
  typedef enum logic [2:0] {
    STREAM_TYPE_R  = 3'd0,
    STREAM_TYPE_AR = 3'd1,
    STREAM_TYPE_AW = 3'd2,
    STREAM_TYPE_W  = 3'd3,
    STREAM_TYPE_B  = 3'd4
  } stream_type_e;

  localparam int RRESP_W = 2;

  function automatic int meta_rresp_lsb(input int id_w);
    return id_w;
  endfunction

  function automatic int meta_rlast_bit(input int id_w);
    return id_w + RRESP_W;
  endfunction

  function automatic int meta_ruser_lsb(input int id_w);
    return id_w + RRESP_W + 1;
  endfunction

  function automatic int meta_type_lsb(input int data_w, input int type_w);
    return data_w - type_w;
  endfunction

endpackage

// File: rtl/stream_r_meta_unpack.sv
// Purely combinational split of an R-beat metadata word into its AXI fields.
// Bits between ruser and the type field carry nothing and are ignored.
module stream_r_meta_unpack
  import stream_to_axi_r_pkg::*;
#(
  parameter int DATA_WIDTH        = 128,
  parameter int ID_WIDTH          = 32,
  parameter int USER_WIDTH        = 64,
  parameter int STREAM_TYPE_WIDTH = 3
) (
  input  logic [DATA_WIDTH-1:0]        i_meta,
  output logic [ID_WIDTH-1:0]          o_rid,
  output logic [1:0]                   o_rresp,
  output logic                         o_rlast,
  output logic [USER_WIDTH-1:0]        o_ruser,
  output logic [STREAM_TYPE_WIDTH-1:0] o_type
);

  localparam int RRESP_LSB = meta_rresp_lsb(ID_WIDTH);
  localparam int RLAST_BIT = meta_rlast_bit(ID_WIDTH);
  localparam int RUSER_LSB = meta_ruser_lsb(ID_WIDTH);
  localparam int TYPE_LSB  = meta_type_lsb(DATA_WIDTH, STREAM_TYPE_WIDTH);

  function automatic logic [DATA_WIDTH-1:0] ignored_mask();
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = RUSER_LSB + USER_WIDTH; i < TYPE_LSB; i++) begin
      m = m | (DATA_WIDTH'(1) << i);
    end
    return m;
  endfunction

  localparam logic [DATA_WIDTH-1:0] IGN_MASK = ignored_mask();

  logic w_unused_ign;

  assign o_rid        = i_meta[ID_WIDTH-1:0];
  assign o_rresp      = i_meta[RRESP_LSB +: RRESP_W];
  assign o_rlast      = i_meta[RLAST_BIT];
  assign o_ruser      = i_meta[RUSER_LSB +: USER_WIDTH];
  assign o_type       = i_meta[TYPE_LSB +: STREAM_TYPE_WIDTH];
  assign w_unused_ign = ^(i_meta & IGN_MASK);

endmodule

// File: rtl/stream_to_axi_r.sv
// Rebuilds AXI R beats from data+metadata stream-word pairs and drives an AXI R master.
// Optional macro STREAM_R_TYPE_CHECK_EN drops pairs whose metadata type differs from STREAM_TYPE.
module stream_to_axi_r
  import stream_to_axi_r_pkg::*;
#(
  parameter int DATA_WIDTH        = 128,
  parameter int ID_WIDTH          = 32,
  parameter int USER_WIDTH        = 64,
  parameter int BURST_LEN         = 8,
  parameter int STREAM_TYPE_WIDTH = 3,
  parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE = STREAM_TYPE_WIDTH'(STREAM_TYPE_R)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  in_progress,
  output logic [ID_WIDTH-1:0]   AXIM_rid,
  output logic [DATA_WIDTH-1:0] AXIM_rdata,
  output logic [1:0]            AXIM_rresp,
  output logic                  AXIM_rlast,
  output logic [USER_WIDTH-1:0] AXIM_ruser,
  output logic                  AXIM_rvalid,
  input  logic                  AXIM_rready,
  output logic                  err_pulse,
  output logic [15:0]           err_count
);

  localparam int               CNT_W   = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN);
  localparam logic [15:0]      ERR_SAT = 16'hFFFF;

  r_state_e r_state;
  r_state_e w_next_state;

  logic [DATA_WIDTH-1:0] r_rdata;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [1:0]            r_rresp;
  logic                  r_rlast;
  logic [USER_WIDTH-1:0] r_ruser;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic                  r_err_pulse;
  logic [15:0]           r_err_count;

  logic [ID_WIDTH-1:0]          w_meta_rid;
  logic [1:0]                   w_meta_rresp;
  logic                         w_meta_rlast;
  logic [USER_WIDTH-1:0]        w_meta_ruser;
  logic [STREAM_TYPE_WIDTH-1:0] w_meta_type;

  logic             w_data_hs;
  logic             w_meta_hs;
  logic             w_meta_load;
  logic             w_r_hs;
  logic             w_type_err;
  logic             w_overrun;
  logic             w_err_event;
  logic [CNT_W-1:0] w_cnt_inc;

  stream_r_meta_unpack #(
    .DATA_WIDTH        (DATA_WIDTH),
    .ID_WIDTH          (ID_WIDTH),
    .USER_WIDTH        (USER_WIDTH),
    .STREAM_TYPE_WIDTH (STREAM_TYPE_WIDTH)
  ) u_meta_unpack (
    .i_meta  (s_data),
    .o_rid   (w_meta_rid),
    .o_rresp (w_meta_rresp),
    .o_rlast (w_meta_rlast),
    .o_ruser (w_meta_ruser),
    .o_type  (w_meta_type)
  );

  assign w_data_hs   = (r_state == WAIT_DATA) && s_valid;
  assign w_meta_hs   = (r_state == WAIT_META) && s_valid;
  assign w_r_hs      = (r_state == DRIVE) && AXIM_rready;
  assign w_meta_load = w_meta_hs && !w_type_err;

`ifdef STREAM_R_TYPE_CHECK_EN
  assign w_type_err = w_meta_hs && (w_meta_type != STREAM_TYPE);
`else
  logic w_unused_type;
  assign w_type_err    = 1'b0;
  assign w_unused_type = ^{w_meta_type, STREAM_TYPE};
`endif

  // A non-last beat that fills the counter is an overrun; the beat still goes out.
  assign w_cnt_inc   = r_beat_cnt + CNT_W'(1);
  assign w_overrun   = w_r_hs && !r_rlast && (w_cnt_inc == CNT_MAX);
  assign w_err_event = w_overrun || w_type_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= WAIT_DATA;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      WAIT_DATA: if (s_valid) w_next_state = WAIT_META;
      WAIT_META: if (s_valid) w_next_state = w_type_err ? WAIT_DATA : DRIVE;
      DRIVE:     if (AXIM_rready) w_next_state = WAIT_DATA;
      default:   w_next_state = WAIT_DATA;
    endcase
  end

  always_comb begin
    s_ready     = 1'b1;
    AXIM_rvalid = 1'b0;
    in_progress = 1'b0;
    case (r_state)
      WAIT_DATA: begin
        s_ready = 1'b1;
      end
      WAIT_META: begin
        in_progress = 1'b1;
      end
      DRIVE: begin
        s_ready     = 1'b0;
        AXIM_rvalid = 1'b1;
        in_progress = 1'b1;
      end
      default: begin
        s_ready = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (w_data_hs) begin
      r_rdata <= s_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rid   <= '0;
      r_rresp <= '0;
      r_rlast <= 1'b0;
      r_ruser <= '0;
    end else if (w_meta_load) begin
      r_rid   <= w_meta_rid;
      r_rresp <= w_meta_rresp;
      r_rlast <= w_meta_rlast;
      r_ruser <= w_meta_ruser;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_beat_cnt <= '0;
    end else if (w_r_hs) begin
      r_beat_cnt <= (r_rlast || w_overrun) ? '0 : w_cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= w_err_event;
      if (w_err_event && (r_err_count != ERR_SAT)) begin
        r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign AXIM_rid   = r_rid;
  assign AXIM_rdata = r_rdata;
  assign AXIM_rresp = r_rresp;
  assign AXIM_rlast = r_rlast;
  assign AXIM_ruser = r_ruser;
  assign err_pulse  = r_err_pulse;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_stream_to_axi_r.sv
// Scoreboard bench for stream_to_axi_r: stream pairs push expected R beats,
// a negedge monitor pops and compares them on every R handshake.
module tb_stream_to_axi_r;

  logic         clk;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] s_data;
  logic         in_progress;
  logic [31:0]  AXIM_rid;
  logic [127:0] AXIM_rdata;
  logic [1:0]   AXIM_rresp;
  logic         AXIM_rlast;
  logic [63:0]  AXIM_ruser;
  logic         AXIM_rvalid;
  logic         AXIM_rready;
  logic         err_pulse;
  logic [15:0]  err_count;

  typedef struct packed {
    logic [31:0]  rid;
    logic [127:0] data;
    logic [1:0]   rresp;
    logic         rlast;
    logic [63:0]  ruser;
  } beat_t;

  beat_t       sb[$];
  beat_t       mon_e;
  int          n_cmp;
  int          n_bad;
  int unsigned cyc;
  int unsigned cyc0;
  logic [15:0] exp_err;
  logic [127:0] bp_data;

  stream_to_axi_r dut (
    .clk         (clk),
    .reset       (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .in_progress (in_progress),
    .AXIM_rid    (AXIM_rid),
    .AXIM_rdata  (AXIM_rdata),
    .AXIM_rresp  (AXIM_rresp),
    .AXIM_rlast  (AXIM_rlast),
    .AXIM_ruser  (AXIM_ruser),
    .AXIM_rvalid (AXIM_rvalid),
    .AXIM_rready (AXIM_rready),
    .err_pulse   (err_pulse),
    .err_count   (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent packing of the metadata word for the default widths.
  function automatic logic [127:0] mk_meta(input logic [31:0] rid, input logic [1:0] rresp,
                                           input logic rlast, input logic [63:0] ruser,
                                           input logic [2:0] typ);
    logic [127:0] m;
    m           = '0;
    m[31:0]     = rid;
    m[33:32]    = rresp;
    m[34]       = rlast;
    m[98:35]    = ruser;
    m[110:100]  = 11'h5A5;
    m[127:125]  = typ;
    return m;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the word's handshake edge.
  task automatic send_word(input logic [127:0] w);
    bit got;
    int n;
    got     = 1'b0;
    n       = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!got && n < 200) begin
      @(negedge clk);
      got = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    s_valid = 1'b0;
    check("send_accept", 128'(got), 128'(1));
  endtask

  task automatic send_beat(input logic [127:0] data, input logic [31:0] rid, input logic [1:0] rresp,
                           input logic rlast, input logic [63:0] ruser, input logic [2:0] typ,
                           input bit push);
    beat_t b;
    b.rid   = rid;
    b.data  = data;
    b.rresp = rresp;
    b.rlast = rlast;
    b.ruser = ruser;
    if (push) sb.push_back(b);
    send_word(data);
    send_word(mk_meta(rid, rresp, rlast, ruser, typ));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 128'(sb.size()), 128'(0));
  endtask

  always @(negedge clk) begin
    if (!rst && AXIM_rvalid && AXIM_rready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_beat", 128'(AXIM_rid), 128'(0));
      end else begin
        mon_e = sb.pop_front();
        check("rid",   128'(AXIM_rid),   128'(mon_e.rid));
        check("rdata", AXIM_rdata,       mon_e.data);
        check("rresp", 128'(AXIM_rresp), 128'(mon_e.rresp));
        check("rlast", 128'(AXIM_rlast), 128'(mon_e.rlast));
        check("ruser", 128'(AXIM_ruser), 128'(mon_e.ruser));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    cyc         = 0;
    exp_err     = 16'd0;
    rst         = 1'b1;
    s_valid     = 1'b0;
    s_data      = '0;
    AXIM_rready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready",   128'(s_ready),     128'(1));
    check("rst_rvalid",    128'(AXIM_rvalid), 128'(0));
    check("rst_inprog",    128'(in_progress), 128'(0));
    check("rst_err_pulse", 128'(err_pulse),   128'(0));
    check("rst_err_count", 128'(err_count),   128'(0));
    check("rst_rdata",     AXIM_rdata,        128'(0));
    check("rst_rid",       128'(AXIM_rid),    128'(0));
    check("rst_rresp",     128'(AXIM_rresp),  128'(0));
    check("rst_rlast",     128'(AXIM_rlast),  128'(0));
    check("rst_ruser",     128'(AXIM_ruser),  128'(0));
    rst = 1'b0;

    // Single beat: rvalid the cycle after meta handshake, for exactly one cycle
    AXIM_rready = 1'b1;
    send_beat({16{8'hA5}}, 32'h7, 2'b00, 1'b1, 64'h0123_4567_89AB_CDEF, 3'b000, 1'b1);
    check("single_rvalid_on",  128'(AXIM_rvalid), 128'(1));
    check("single_inprog",     128'(in_progress), 128'(1));
    check("single_s_ready",    128'(s_ready),     128'(0));
    @(posedge clk);
    #1;
    check("single_rvalid_off", 128'(AXIM_rvalid), 128'(0));
    check("single_inprog_off", 128'(in_progress), 128'(0));
    drain();

    // Backpressure: 10 cycles of rready=0 with the next pair already pending
    AXIM_rready = 1'b0;
    bp_data     = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    send_beat(bp_data, 32'h11, 2'b10, 1'b1, 64'hFEED, 3'b000, 1'b1);
    fork
      send_beat(128'hC0C0_C0C0, 32'h12, 2'b01, 1'b1, 64'hBEEF, 3'b000, 1'b1);
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          check("bp_rvalid",  128'(AXIM_rvalid), 128'(1));
          check("bp_s_ready", 128'(s_ready),     128'(0));
          check("bp_rdata",   AXIM_rdata,        bp_data);
          check("bp_rid",     128'(AXIM_rid),    128'(32'h11));
        end
        @(posedge clk);
        #1;
        AXIM_rready = 1'b1;
      end
    join
    drain();

    // Burst of 8, rlast only on the last, back-to-back: 3 cycles per beat, no error
    cyc0 = cyc;
    for (int i = 0; i < 8; i++) begin
      send_beat({4{32'h1000_0000 + 32'(i)}}, 32'(i), 2'b00, (i == 7), {32'hC0DE_0000, 32'(i)}, 3'b000, 1'b1);
    end
    check("burst_cycles", 128'(cyc - cyc0), 128'(23));
    @(posedge clk);
    #1;
    check("burst_err_pulse", 128'(err_pulse), 128'(0));
    check("burst_err_count", 128'(err_count), 128'(exp_err));

    // Overrun: 8 beats with no rlast; error only on the 8th
    for (int i = 0; i < 7; i++) begin
      send_beat(128'(32'h2000 + i), 32'(i + 100), 2'b00, 1'b0, 64'(i), 3'b000, 1'b1);
    end
    @(posedge clk);
    #1;
    check("pre_ovr_err_pulse", 128'(err_pulse), 128'(0));
    check("pre_ovr_err_count", 128'(err_count), 128'(exp_err));
    send_beat(128'h2007, 32'd107, 2'b11, 1'b0, 64'd7, 3'b000, 1'b1);
    @(posedge clk);
    #1;
    exp_err = exp_err + 16'd1;
    check("ovr_err_pulse", 128'(err_pulse), 128'(1));
    check("ovr_err_count", 128'(err_count), 128'(exp_err));
    @(posedge clk);
    #1;
    check("ovr_err_pulse_off", 128'(err_pulse), 128'(0));
    drain();

    // Foreign type code in metadata
`ifdef STREAM_R_TYPE_CHECK_EN
    send_beat(128'h7777, 32'h33, 2'b00, 1'b1, 64'h1, 3'b101, 1'b0);
    check("type_rvalid", 128'(AXIM_rvalid), 128'(0));
    check("type_err_pulse", 128'(err_pulse), 128'(1));
    exp_err = exp_err + 16'd1;
`else
    send_beat(128'h7777, 32'h33, 2'b00, 1'b1, 64'h1, 3'b101, 1'b1);
    check("type_rvalid", 128'(AXIM_rvalid), 128'(1));
    check("type_err_pulse", 128'(err_pulse), 128'(0));
`endif
    @(posedge clk);
    #1;
    check("type_err_count", 128'(err_count), 128'(exp_err));
    send_beat(128'h8888, 32'h34, 2'b01, 1'b1, 64'h2, 3'b000, 1'b1);
    drain();

    // Async reset in WAIT_META, then in DRIVE
    send_word(128'h9999);
    check("wm_inprog", 128'(in_progress), 128'(1));
    #2 rst = 1'b1;
    #1;
    check("wm_rst_inprog",  128'(in_progress), 128'(0));
    check("wm_rst_s_ready", 128'(s_ready),     128'(1));
    check("wm_rst_errcnt",  128'(err_count),   128'(0));
    exp_err = 16'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    AXIM_rready = 1'b0;
    send_beat(128'hAAAA, 32'h44, 2'b00, 1'b1, 64'h3, 3'b000, 1'b0);
    check("dr_rvalid", 128'(AXIM_rvalid), 128'(1));
    #2 rst = 1'b1;
    #1;
    check("dr_rst_rvalid", 128'(AXIM_rvalid), 128'(0));
    check("dr_rst_rdata",  AXIM_rdata,        128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    AXIM_rready = 1'b1;
    send_beat(128'hBBBB_CCCC, 32'h55, 2'b10, 1'b1, 64'h4, 3'b000, 1'b1);
    check("post_rst_rvalid", 128'(AXIM_rvalid), 128'(1));
    drain();

    // Saturation: preload near the top, then two overruns
    force dut.r_err_count = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.r_err_count;
    check("sat_preload", 128'(err_count), 128'(16'hFFFE));
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        send_beat(128'(32'h3000 + i), 32'(i), 2'b00, 1'b0, 64'(k), 3'b000, 1'b1);
      end
      @(posedge clk);
      #1;
      check("sat_err_pulse", 128'(err_pulse), 128'(1));
      check("sat_err_count", 128'(err_count), 128'(16'hFFFF));
    end
    drain();

    check("final_sb_empty", 128'(sb.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
